// File: rtl/intc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : intc_pkg
//  Description : Shared constants and helpers for the vectored interrupt
//                controller (register offsets, source limit, block decode).
//  Revision    : 1.0 - initial release
// ============================================================================
package intc_pkg;

    // Upper bound on the number of interrupt sources; also the width of
    // the register bus data path.
    localparam int MAX_IRQ = 32;

    // Word offsets inside the 32-byte register block (input_addr[4:2]).
    typedef logic [2:0] reg_off_t;

    localparam reg_off_t OFF_PENDING = 3'd0;
    localparam reg_off_t OFF_MASK    = 3'd1;
    localparam reg_off_t OFF_MODE    = 3'd2;
    localparam reg_off_t OFF_INSVC   = 3'd3;
    localparam reg_off_t OFF_EOI     = 3'd4;

    // Block hit test.
    // Only address bits [31:5] take part, so callers pass those bits alone.
    function automatic logic blk_hit(input logic [26:0] addr_hi,
                                     input logic [26:0] base_hi);
        return (addr_hi == base_hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/intc_src.sv
`default_nettype none
// ============================================================================
//  Module      : intc_src
//  Description : One interrupt source: input history flop, edge/level event
//                detection and the pending flop. A new event wins over a
//                W1C or acknowledge clear in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module intc_src (
    input  logic clk,
    input  logic rst,
    input  logic done,
    input  logic mode,      // 1 = edge, 0 = level
    input  logic w1c,
    input  logic ack_clr,
    output logic pending
);

    logic done_d_q;
    logic pending_q;
    logic pending_d;
    logic w_set;

    // Event detect, then set-over-clear next state for the pending bit.
    always_comb begin
        w_set     = mode ? (done & ~done_d_q) : done;
        pending_d = w_set | (pending_q & ~w1c & ~ack_clr);
    end

    // History flop runs every cycle regardless of mode; pending latches events.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_d_q  <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            done_d_q  <= done;
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;

endmodule
`default_nettype wire

// File: rtl/intc_vec.sv
`default_nettype none
// ============================================================================
//  Module      : intc_vec
//  Description : Vectored interrupt controller for NUM_IRQ sources. Holds
//                MASK, MODE, INSVC and the active flag, performs fixed
//                lowest-index-first arbitration, drives the ISR vector and
//                decodes the single-cycle register bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module intc_vec
    import intc_pkg::*;
#(
    parameter int                 NUM_IRQ    = 4,
    parameter int                 SEL_W      = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1,
    parameter logic [31:0]        BASE_ADDR  = 32'h0000_0000,
    parameter logic [NUM_IRQ-1:0] MODE_RESET = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IRQ-1:0]      done,
    input  logic [NUM_IRQ*32-1:0]   vec_addr,
    input  logic [31:0]             input_addr,
    input  logic [31:0]             write_data,
    input  logic                    write_enable,
    input  logic                    IACK,
    output logic                    IRQ,
    output logic [31:0]             isr_addr,
    output logic [SEL_W-1:0]        priority_select,
    output logic [31:0]             read_data
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NUM_IRQ-1:0] mask_q,  mask_d;
    logic [NUM_IRQ-1:0] mode_q,  mode_d;
    logic [NUM_IRQ-1:0] insvc_q, insvc_d;
    logic               active_q, active_d;

    // ------------------------------------------------------------------
    // Combinational nets
    // ------------------------------------------------------------------
    logic               w_hit;
    reg_off_t           w_off;
    logic               w_wr;
    logic [NUM_IRQ-1:0] w_pending;
    logic [NUM_IRQ-1:0] w_eligible;
    logic [SEL_W-1:0]   w_sel;
    logic [NUM_IRQ-1:0] w_sel_oh;
    logic               w_irq;
    logic               w_ack;
    logic               w_eoi;
    logic [NUM_IRQ-1:0] w_w1c;
    logic [NUM_IRQ-1:0] w_ack_clr;
    logic [31:0]        w_isr;
    logic [MAX_IRQ-1:0] w_rd;

    // Address bits below the word offset and the write-data bits above
    // NUM_IRQ are architecturally ignored.
    logic w_unused_bits;
    assign w_unused_bits = ^{input_addr[1:0], write_data};

    // Bus decode: block hit, word offset and qualified write strobes.
    always_comb begin
        w_hit = blk_hit(input_addr[31:5], BASE_ADDR[31:5]);
        w_off = input_addr[4:2];
        w_wr  = write_enable & w_hit;
        w_eoi = w_wr & (w_off == OFF_EOI);
        w_w1c = (w_wr && (w_off == OFF_PENDING)) ? write_data[NUM_IRQ-1:0] : '0;
    end

    // ------------------------------------------------------------------
    // Per-source capture
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_src
        intc_src u_src (
            .clk     (clk),
            .rst     (rst),
            .done    (done[gi]),
            .mode    (mode_q[gi]),
            .w1c     (w_w1c[gi]),
            .ack_clr (w_ack_clr[gi]),
            .pending (w_pending[gi])
        );
    end

    // Priority encoder: scan high to low so the lowest eligible index wins.
    always_comb begin
        w_eligible = w_pending & mask_q;
        w_sel      = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_sel = SEL_W'(i);
            end
        end
    end

    // One-hot of the winner, vector mux and request/acknowledge qualification.
    always_comb begin
        w_sel_oh = '0;
        w_isr    = vec_addr[31:0];
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (w_sel == SEL_W'(i)) begin
                w_sel_oh[i] = 1'b1;
                w_isr       = vec_addr[32*i +: 32];
            end
        end
        w_irq     = (|w_eligible) & ~active_q;
        w_ack     = IACK & w_irq;
        w_ack_clr = w_ack ? w_sel_oh : '0;
    end

    // Next state for the control registers and the in-service tracking.
    // An acknowledge needs active=0 and an EOI only clears, so the two never
    // collide in a meaningful way.
    always_comb begin
        mask_d   = mask_q;
        mode_d   = mode_q;
        insvc_d  = insvc_q;
        active_d = active_q;
        if (w_wr && (w_off == OFF_MASK)) begin
            mask_d = write_data[NUM_IRQ-1:0];
        end
        if (w_wr && (w_off == OFF_MODE)) begin
            mode_d = write_data[NUM_IRQ-1:0];
        end
        if (w_ack) begin
            insvc_d  = w_sel_oh;
            active_d = 1'b1;
        end else if (w_eoi) begin
            insvc_d  = '0;
            active_d = 1'b0;
        end
    end

    // Register update with asynchronous reset; mask comes up fully enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q   <= '1;
            mode_q   <= MODE_RESET;
            insvc_q  <= '0;
            active_q <= 1'b0;
        end else begin
            mask_q   <= mask_d;
            mode_q   <= mode_d;
            insvc_q  <= insvc_d;
            active_q <= active_d;
        end
    end

    // Zero-latency read mux; misses and unmapped offsets return zero.
    always_comb begin
        w_rd = '0;
        if (w_hit) begin
            case (w_off)
                OFF_PENDING: w_rd[NUM_IRQ-1:0] = w_pending;
                OFF_MASK:    w_rd[NUM_IRQ-1:0] = mask_q;
                OFF_MODE:    w_rd[NUM_IRQ-1:0] = mode_q;
                OFF_INSVC:   w_rd[NUM_IRQ-1:0] = insvc_q;
                default:     w_rd = '0;
            endcase
        end
    end

    assign IRQ             = w_irq;
    assign priority_select = w_sel;
    assign isr_addr        = w_isr;
    assign read_data       = w_rd;

endmodule
`default_nettype wire

// File: tb/tb_intc_vec.sv
`default_nettype none
// ============================================================================
//  Module      : tb_intc_vec
//  Description : Directed self-checking bench for intc_vec: a 4-source
//                instance for the main scenarios and a 32-source instance
//                for wide arbitration and asynchronous reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_intc_vec;

    localparam logic [31:0] c_A_PEND  = 32'h00;
    localparam logic [31:0] c_A_MASK  = 32'h04;
    localparam logic [31:0] c_A_MODE  = 32'h08;
    localparam logic [31:0] c_A_INSVC = 32'h0C;
    localparam logic [31:0] c_A_EOI   = 32'h10;
    localparam logic [31:0] c_BASE32  = 32'h0000_0100;

    logic clk;
    logic rst;

    // 4-source instance
    logic [3:0]     done;
    logic [127:0]   vec_addr;
    logic [31:0]    input_addr;
    logic [31:0]    write_data;
    logic           write_enable;
    logic           IACK;
    logic           IRQ;
    logic [31:0]    isr_addr;
    logic [1:0]     priority_select;
    logic [31:0]    read_data;

    // 32-source instance
    logic [31:0]    done32;
    logic [1023:0]  vec32;
    logic [31:0]    addr32;
    logic [31:0]    wdata32;
    logic           we32;
    logic           iack32;
    logic           irq32;
    logic [31:0]    isr32;
    logic [4:0]     sel32;
    logic [31:0]    rd32;

    int n_total;
    int n_bad;

    intc_vec #(
        .NUM_IRQ    (4),
        .BASE_ADDR  (32'h0000_0000),
        .MODE_RESET (4'b0000)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .done            (done),
        .vec_addr        (vec_addr),
        .input_addr      (input_addr),
        .write_data      (write_data),
        .write_enable    (write_enable),
        .IACK            (IACK),
        .IRQ             (IRQ),
        .isr_addr        (isr_addr),
        .priority_select (priority_select),
        .read_data       (read_data)
    );

    intc_vec #(
        .NUM_IRQ    (32),
        .BASE_ADDR  (c_BASE32),
        .MODE_RESET (32'h0)
    ) u_dut32 (
        .clk             (clk),
        .rst             (rst),
        .done            (done32),
        .vec_addr        (vec32),
        .input_addr      (addr32),
        .write_data      (wdata32),
        .write_enable    (we32),
        .IACK            (iack32),
        .IRQ             (irq32),
        .isr_addr        (isr32),
        .priority_select (sel32),
        .read_data       (rd32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] vec_of(input int i);
        return 32'h1000_0000 + 32'(i) * 32'h100;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and checks happen 2 time units later.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        input_addr   = a;
        write_data   = d;
        write_enable = 1'b1;
        step();
        write_enable = 1'b0;
        write_data   = 32'h0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        input_addr = a;
        #1;
        chk(tag, read_data, exp);
    endtask

    task automatic ack_eoi();
        IACK = 1'b1;
        step();
        IACK = 1'b0;
        wr(c_A_EOI, 32'h0);
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst = 1'b1;
        done = '0; input_addr = '0; write_data = '0; write_enable = 1'b0; IACK = 1'b0;
        done32 = '0; addr32 = c_BASE32; wdata32 = '0; we32 = 1'b0; iack32 = 1'b0;
        for (int i = 0; i < 4; i++)  vec_addr[32*i +: 32] = vec_of(i);
        for (int i = 0; i < 32; i++) vec32[32*i +: 32]    = vec_of(i);

        // ---- reset state ----
        #12;
        rst = 1'b0;
        step();
        rd_chk("rst_mask", c_A_MASK, 32'hF);
        rd_chk("rst_pend", c_A_PEND, 32'h0);
        chk("rst_irq", {31'b0, IRQ}, 32'h0);
        chk("rst_isr", isr_addr, vec_of(0));

        // ---- level mode ----
        done = 4'b0110;
        step();
        done = 4'b0000;
        chk("lvl_irq", {31'b0, IRQ}, 32'h1);
        chk("lvl_sel", {30'b0, priority_select}, 32'd1);
        chk("lvl_isr", isr_addr, vec_of(1));
        IACK = 1'b1;
        step();
        IACK = 1'b0;
        rd_chk("lvl_insvc", c_A_INSVC, 32'h2);
        rd_chk("lvl_pend", c_A_PEND, 32'h4);
        chk("lvl_irq_act", {31'b0, IRQ}, 32'h0);
        wr(c_A_EOI, 32'hDEAD_BEEF);
        chk("eoi_irq", {31'b0, IRQ}, 32'h1);
        chk("eoi_sel", {30'b0, priority_select}, 32'd2);
        rd_chk("eoi_insvc", c_A_INSVC, 32'h0);
        ack_eoi();
        rd_chk("lvl_drain", c_A_PEND, 32'h0);

        // ---- edge mode ----
        wr(c_A_MODE, 32'hF);
        rd_chk("mode_rb", c_A_MODE, 32'hF);
        done = 4'b1000;
        repeat (5) step();
        rd_chk("edge_pend", c_A_PEND, 32'h8);
        chk("edge_sel", {30'b0, priority_select}, 32'd3);
        ack_eoi();
        chk("edge_irq_hi", {31'b0, IRQ}, 32'h0);
        rd_chk("edge_pend2", c_A_PEND, 32'h0);
        done = 4'b0000;
        step();

        // ---- masking ----
        wr(c_A_MASK, 32'hE);
        done = 4'b0101;
        step();
        done = 4'b0000;
        chk("msk_sel", {30'b0, priority_select}, 32'd2);
        chk("msk_isr", isr_addr, vec_of(2));
        wr(c_A_MASK, 32'hF);
        chk("unmsk_sel", {30'b0, priority_select}, 32'd0);
        ack_eoi();
        chk("msk_next", {30'b0, priority_select}, 32'd2);
        ack_eoi();
        rd_chk("msk_drain", c_A_PEND, 32'h0);

        // ---- W1C racing a new edge ----
        done         = 4'b0001;
        input_addr   = c_A_PEND;
        write_data   = 32'h1;
        write_enable = 1'b1;
        step();
        write_enable = 1'b0;
        done         = 4'b0000;
        rd_chk("w1c_race", c_A_PEND, 32'h1);
        wr(c_A_PEND, 32'h1);
        rd_chk("w1c_clr", c_A_PEND, 32'h0);

        // ---- IACK while IRQ=0 (source pending but masked) ----
        wr(c_A_MASK, 32'h0);
        done = 4'b0010;
        step();
        done = 4'b0000;
        chk("mskd_irq", {31'b0, IRQ}, 32'h0);
        IACK = 1'b1;
        step();
        IACK = 1'b0;
        rd_chk("nack_insvc", c_A_INSVC, 32'h0);
        rd_chk("nack_pend", c_A_PEND, 32'h2);
        wr(c_A_MASK, 32'hF);
        chk("nack_sel", {30'b0, priority_select}, 32'd1);
        ack_eoi();

        // ---- decode: unmapped offset, miss, ignored write ----
        rd_chk("unmap_rd", 32'h14, 32'h0);
        rd_chk("miss_rd", 32'h24, 32'h0);
        wr(c_A_INSVC, 32'hF);
        rd_chk("ro_insvc", c_A_INSVC, 32'h0);
        wr(32'h0000_0024, 32'h0);
        rd_chk("miss_wr", c_A_MASK, 32'hF);

        // ---- 32-source instance ----
        addr32 = c_BASE32 + c_A_MASK;
        #1;
        chk("w_mask", rd32, 32'hFFFF_FFFF);
        done32 = 32'h8002_0000;
        step();
        done32 = '0;
        chk("w_sel", {27'b0, sel32}, 32'd17);
        chk("w_isr", isr32, vec_of(17));
        iack32 = 1'b1;
        step();
        iack32 = 1'b0;
        addr32 = c_BASE32 + c_A_INSVC;
        #1;
        chk("w_insvc", rd32, 32'h0002_0000);
        chk("w_irq_act", {31'b0, irq32}, 32'h0);
        addr32 = c_BASE32 + c_A_PEND;
        #1;
        chk("w_pend", rd32, 32'h8000_0000);

        // ---- asynchronous reset while active, no clock edge ----
        rst = 1'b1;
        #1;
        addr32 = c_BASE32 + c_A_INSVC;
        #1;
        chk("ar_insvc", rd32, 32'h0);
        chk("ar_irq", {31'b0, irq32}, 32'h0);
        addr32 = c_BASE32 + c_A_PEND;
        #1;
        chk("ar_pend", rd32, 32'h0);
        rst = 1'b0;
        step();
        chk("ar_irq_after", {31'b0, irq32}, 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
